demux_rr_dispatcher: RTL and testbench

DEMUX_RR_DISPATCHER -- requirements
Module: demux_rr_dispatcher

---
 rtl/demux_disp_pkg.sv | 14 +
 rtl/demux_rr_pick.sv | 36 +++
 rtl/demux_rr_dispatcher.sv | 103 ++++++++++
 tb/tb_demux_rr_dispatcher.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_disp_pkg.sv
// Shared types and constants for the round-robin demux dispatcher.
// Optional feature macro: DEMUX_DISP_SKIP_EN (skip non-ready destinations).
package demux_disp_pkg;

    localparam int NUM_DEST = 4;

    typedef logic [1:0] dest_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage : demux_disp_pkg

// File: rtl/demux_rr_pick.sv
// Next-destination selection for the dispatcher (purely combinational).
// Default: strict rotation, the destination is always the pointer.
// With DEMUX_DISP_SKIP_EN: the first ready destination starting at the
// pointer wins, falling back to the pointer when none is ready; the pointer
// then moves one past the chosen destination.
module demux_rr_pick
    import demux_disp_pkg::*;
(
    input  dest_idx_t           ptr_i,
`ifdef DEMUX_DISP_SKIP_EN
    input  logic [NUM_DEST-1:0] ready_i,
`endif
    output dest_idx_t           dest_o,
    output dest_idx_t           next_ptr_o
);

`ifdef DEMUX_DISP_SKIP_EN
    // Scan from the farthest candidate back to ptr so the nearest ready one wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        dest_o = ptr_i;
        for (int k = NUM_DEST - 1; k >= 0; k--) begin
            if (ready_i[ptr_i + dest_idx_t'(k)]) begin
                dest_o = ptr_i + dest_idx_t'(k);
            end
        end
    end
`else
    assign dest_o = ptr_i;
`endif

    // The pointer always resumes just after the destination actually used.
    assign next_ptr_o = dest_o + dest_idx_t'(1);

endmodule : demux_rr_pick

// File: rtl/demux_rr_dispatcher.sv
// Round-robin demux dispatcher: one holding register fed by a valid/ready
// source and delivered to one of four destinations in rotation.
// Optional feature macro: DEMUX_DISP_SKIP_EN (see demux_rr_pick).
module demux_rr_dispatcher
    import demux_disp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [NUM_DEST-1:0] out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic [NUM_DEST-1:0] out_ready,
    output logic [1:0]          sel,
    output logic [CNT_W-1:0]    disp_cnt
);

    state_e            state_q;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    dest_idx_t         buf_dest_q, buf_dest_d;
    dest_idx_t         ptr_q, ptr_d;
    logic [CNT_W-1:0]  disp_cnt_q, disp_cnt_d;
    dest_idx_t         pick_dest, pick_next;
    logic              buf_valid, out_hs, in_hs;

    assign buf_valid = (state_q == FULL);
    assign out_hs    = buf_valid && out_ready[buf_dest_q];
    // Accept while empty, or while full when the held word leaves this cycle.
    assign in_ready  = !buf_valid || out_hs;
    assign in_hs     = in_valid && in_ready;

    demux_rr_pick u_pick (
        .ptr_i      (ptr_q),
`ifdef DEMUX_DISP_SKIP_EN
        .ready_i    (out_ready),
`endif
        .dest_o     (pick_dest),
        .next_ptr_o (pick_next)
    );

    // Next-state values for the holding register, pointer and counter.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_dest_d = buf_dest_q;
        ptr_d      = ptr_q;
        disp_cnt_d = disp_cnt_q;
        if (in_hs) begin
            buf_data_d = in_data;
            buf_dest_d = pick_dest;
            ptr_d      = pick_next;
        end
        if (out_hs) begin
            disp_cnt_d = disp_cnt_q + 1'b1;
        end
    end

    // FSM: EMPTY fills on input handshake; FULL drains only without a refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            case (state_q)
                EMPTY:   if (in_hs) state_q <= FULL;
                FULL:    if (out_hs && !in_hs) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data word is reset too so out_data reads zero after
            // reset rather than a stale, discarded word.
            buf_data_q <= '0;
            buf_dest_q <= '0;
            ptr_q      <= '0;
            disp_cnt_q <= '0;
        end else begin
            buf_data_q <= buf_data_d;
            buf_dest_q <= buf_dest_d;
            ptr_q      <= ptr_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    // One-hot valid decoded from the held destination; all zero when empty.
    always_comb begin
        out_valid             = '0;
        out_valid[buf_dest_q] = buf_valid;
    end

    assign out_data = buf_data_q;
    assign sel      = buf_dest_q;
    assign disp_cnt = disp_cnt_q;

endmodule : demux_rr_dispatcher

// File: tb/tb_demux_rr_dispatcher.sv
// Directed and random bench for demux_rr_dispatcher (CNT_W=4 so the counter
// wrap is reachable). Expectations follow DEMUX_DISP_SKIP_EN when defined.
module tb_demux_rr_dispatcher;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_ready;
    logic [1:0]        sel;
    logic [CNT_W-1:0]  disp_cnt;

    int n_cmp = 0;
    int n_err = 0;

    demux_rr_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .disp_cnt  (disp_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0000", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
        n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL rst_sel: got %0d expected 0", sel); end
        n_cmp++; if (disp_cnt !== 4'd0) begin n_err++; $display("FAIL rst_disp_cnt: got %0d expected 0", disp_cnt); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ov;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 4'hF;
        in_data   = 8'hA1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ov = 4'(1 << (i % 4));
            n_cmp++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL b2b_out_valid[%0d]: got %b expected %b", i, out_valid, exp_ov); end
            n_cmp++; if (out_data !== 8'(8'hA1 + i)) begin n_err++; $display("FAIL b2b_out_data[%0d]: got %h expected %h", i, out_data, 8'(8'hA1 + i)); end
            n_cmp++; if (disp_cnt !== CNT_W'(i)) begin n_err++; $display("FAIL b2b_disp_cnt[%0d]: got %0d expected %0d", i, disp_cnt, i); end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            if (i < 4) in_data = 8'(8'hA2 + i);
            else       in_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL b2b_drain_valid: got %b expected 0000", out_valid); end
        n_cmp++; if (disp_cnt !== 4'd5) begin n_err++; $display("FAIL b2b_final_cnt: got %0d expected 5", disp_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (out_valid !== 4'b0001) begin n_err++; $display("FAIL stall_out_valid[%0d]: got %b expected 0001", c, out_valid); end
            n_cmp++; if (out_data !== 8'h55) begin n_err++; $display("FAIL stall_out_data[%0d]: got %h expected 55", c, out_data); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready); end
            @(negedge clk);
        end
        out_ready = 4'b0001;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL stall_delivered: got %b expected 0000", out_valid); end
        n_cmp++; if (disp_cnt !== 4'd1) begin n_err++; $display("FAIL stall_disp_cnt: got %0d expected 1", disp_cnt); end
    endtask

    task automatic test_dest_select();
        do_reset();
        in_valid  = 1'b1;
        in_data   = 8'h10;
        out_ready = 4'hF;
        @(posedge clk);
        @(negedge clk);
        in_data   = 8'h11;
        out_ready = 4'b1101;
        @(posedge clk);
        @(negedge clk);
`ifdef DEMUX_DISP_SKIP_EN
        n_cmp++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL skip_first_valid: got %b expected 0100", out_valid); end
        n_cmp++; if (sel !== 2'd2) begin n_err++; $display("FAIL skip_first_sel: got %0d expected 2", sel); end
        in_data = 8'h22;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b1000) begin n_err++; $display("FAIL skip_second_valid: got %b expected 1000", out_valid); end
        n_cmp++; if (sel !== 2'd3) begin n_err++; $display("FAIL skip_second_sel: got %0d expected 3", sel); end
        n_cmp++; if (out_data !== 8'h22) begin n_err++; $display("FAIL skip_second_data: got %h expected 22", out_data); end
        n_cmp++; if (disp_cnt !== 4'd2) begin n_err++; $display("FAIL skip_cnt: got %0d expected 2", disp_cnt); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (disp_cnt !== 4'd3) begin n_err++; $display("FAIL skip_final_cnt: got %0d expected 3", disp_cnt); end
`else
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL strict_data: got %h expected 11", out_data); end
        for (int c = 0; c < 8; c++) begin
            n_cmp++; if (out_valid !== 4'b0010) begin n_err++; $display("FAIL strict_wait_valid[%0d]: got %b expected 0010", c, out_valid); end
            n_cmp++; if (sel !== 2'd1) begin n_err++; $display("FAIL strict_wait_sel[%0d]: got %0d expected 1", c, sel); end
            n_cmp++; if (disp_cnt !== 4'd1) begin n_err++; $display("FAIL strict_wait_cnt[%0d]: got %0d expected 1", c, disp_cnt); end
            @(negedge clk);
        end
        out_ready = 4'hF;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL strict_release_valid: got %b expected 0000", out_valid); end
        n_cmp++; if (disp_cnt !== 4'd2) begin n_err++; $display("FAIL strict_release_cnt: got %0d expected 2", disp_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid  = 1'b1;
        in_data   = 8'h10;
        out_ready = 4'hF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0010) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 0010", out_valid); end
        n_cmp++; if (disp_cnt !== 4'd1) begin n_err++; $display("FAIL mid_pre_cnt: got %0d expected 1", disp_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0000", out_valid); end
        n_cmp++; if (disp_cnt !== 4'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d expected 0", disp_cnt); end
        n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL mid_rst_sel: got %0d expected 0", sel); end
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL mid_after_valid[%0d]: got %b expected 0000", c, out_valid); end
            n_cmp++; if (disp_cnt !== 4'd0) begin n_err++; $display("FAIL mid_after_cnt[%0d]: got %0d expected 0", c, disp_cnt); end
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        in_valid  = 1'b1;
        out_ready = 4'hF;
        for (int i = 1; i <= 17; i++) begin
            in_data = 8'(i);
            @(posedge clk);
            @(negedge clk);
            if (i == 16) begin
                n_cmp++; if (disp_cnt !== 4'd15) begin n_err++; $display("FAIL wrap_at15: got %0d expected 15", disp_cnt); end
            end
            if (i == 17) begin
                n_cmp++; if (disp_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_at0: got %0d expected 0", disp_cnt); end
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (disp_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_final: got %0d expected 1", disp_cnt); end
    endtask

    task automatic test_random();
        logic              m_valid = 1'b0;
        logic [DATA_W-1:0] m_data  = '0;
        logic [1:0]        m_dest  = '0;
        logic [1:0]        m_ptr   = '0;
        logic [CNT_W-1:0]  m_cnt   = '0;
        logic [3:0]        exp_ov;
        logic              exp_out_hs, exp_in_ready;
        logic [DATA_W-1:0] sb_q[$];
        logic [DATA_W-1:0] sb_head;
        int                bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            #1;
            exp_ov       = m_valid ? 4'(1 << m_dest) : 4'b0000;
            exp_out_hs   = m_valid && out_ready[m_dest];
            exp_in_ready = !m_valid || exp_out_hs;
            n_cmp++; if (out_valid !== exp_ov) begin n_err++; bad++; if (bad < 10) $display("FAIL rnd_out_valid@%0d: got %b expected %b", cyc, out_valid, exp_ov); end
            n_cmp++; if (!$onehot0(out_valid)) begin n_err++; bad++; if (bad < 10) $display("FAIL rnd_onehot@%0d: got %b expected at most one bit", cyc, out_valid); end
            n_cmp++; if (in_ready !== exp_in_ready) begin n_err++; bad++; if (bad < 10) $display("FAIL rnd_in_ready@%0d: got %b expected %b", cyc, in_ready, exp_in_ready); end
            n_cmp++; if (disp_cnt !== m_cnt) begin n_err++; bad++; if (bad < 10) $display("FAIL rnd_disp_cnt@%0d: got %0d expected %0d", cyc, disp_cnt, m_cnt); end
            if (m_valid) begin
                n_cmp++; if (sel !== m_dest) begin n_err++; bad++; if (bad < 10) $display("FAIL rnd_sel@%0d: got %0d expected %0d", cyc, sel, m_dest); end
            end
            if (exp_out_hs) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++; bad++; if (bad < 10) $display("FAIL rnd_sb_empty@%0d: got delivery %h expected none", cyc, out_data);
                end else begin
                    sb_head = sb_q.pop_front();
                    if (out_data !== sb_head) begin n_err++; bad++; if (bad < 10) $display("FAIL rnd_order@%0d: got %h expected %h", cyc, out_data, sb_head); end
                end
                m_cnt = m_cnt + 1'b1;
            end
            if (in_valid && exp_in_ready) begin
                m_dest = m_ptr;
`ifdef DEMUX_DISP_SKIP_EN
                for (int k = 3; k >= 0; k--) begin
                    if (out_ready[2'(m_ptr + k)]) m_dest = 2'(m_ptr + k);
                end
`endif
                m_ptr   = m_dest + 2'd1;
                m_data  = in_data;
                m_valid = 1'b1;
                sb_q.push_back(in_data);
            end else if (exp_out_hs) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++; if (sb_q.size() != int'(m_valid)) begin n_err++; $display("FAIL rnd_sb_level: got %0d expected %0d", sb_q.size(), int'(m_valid)); end
        if (m_valid) begin
            n_cmp++; if (out_data !== m_data) begin n_err++; $display("FAIL rnd_held_data: got %h expected %h", out_data, m_data); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_dest_select();
        test_reset_mid();
        test_cnt_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_demux_rr_dispatcher
